// File: rtl/sram_like_pkg.sv
// Shared encodings, strobe decoder and response record for the SRAM-like bus bridge.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } resp_t;

  // Returns {size, addr[1:0]}; unsupported strobe patterns fall back to a byte at offset 0.
  function automatic logic [3:0] sel_to_size_off(input logic [3:0] sel);
    logic [3:0] r;
    case (sel)
      4'b0001: r = {SZ_BYTE, 2'd0};
      4'b0010: r = {SZ_BYTE, 2'd1};
      4'b0100: r = {SZ_BYTE, 2'd2};
      4'b1000: r = {SZ_BYTE, 2'd3};
      4'b0011: r = {SZ_HALF, 2'd0};
      4'b1100: r = {SZ_HALF, 2'd2};
      4'b1111: r = {SZ_WORD, 2'd0};
      4'b0111: r = {SZ_WORD, 2'd0};
      4'b1110: r = {SZ_WORD, 2'd1};
      default: r = {SZ_BYTE, 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_like_tag_fifo.sv
// Small FIFO of 1-bit tags remembering whether each outstanding bus transaction is a write.
module sram_like_tag_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_data,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] slot;
  logic [PW-1:0]    wptr_reg;
  logic [PW-1:0]    rptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt_reg != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt_reg == FULL_CNT);
  assign count   = cnt_reg;
  assign head    = slot[rptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic tag_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_reg <= 1'b0;
        end else if (do_push && (wptr_reg == PW'(gi))) begin
          tag_reg <= push_data;
        end
      end
      assign slot[gi] = tag_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (do_push) wptr_reg <= (wptr_reg == LAST) ? '0 : wptr_reg + PW'(1);
      if (do_pop)  rptr_reg <= (rptr_reg == LAST) ? '0 : rptr_reg + PW'(1);
      if (do_push && !do_pop)      cnt_reg <= cnt_reg + CW'(1);
      else if (!do_push && do_pop) cnt_reg <= cnt_reg - CW'(1);
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// CPU-to-SRAM-like bus master with a one-entry hold register and up to MAX_OUT outstanding transactions.
// Build macros: SRAM_LIKE_BYPASS_EN (zero-latency CPU-to-bus path), SRAM_LIKE_BRIDGE_ASSERT (protocol check).
module sram_like_bridge
  import sram_like_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_wr,
  input  logic [3:0]        cpu_sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [31:0]       resp_rdata,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata
);

  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] MAX_V = CW1'(MAX_OUT);

  logic              hold_v_reg;
  logic              hold_wr_reg;
  logic [1:0]        hold_size_reg;
  logic [ADDR_W-1:0] hold_addr_reg;
  logic [31:0]       hold_wdata_reg;
  logic              resp_valid_reg;
  resp_t             resp_reg;

  logic [CW-1:0]     out_cnt;
  logic              fifo_full;
  logic              head_wr;
  logic [3:0]        enc;
  logic [ADDR_W-1:0] cpu_bus_addr;
  logic              cnt_ok;
  logic              accept;
  logic              direct;
  logic              issue;
  logic              pop;
  logic              unused_addr_lo;

  assign enc            = sel_to_size_off(cpu_sel);
  assign cpu_bus_addr   = {cpu_addr[ADDR_W-1:2], enc[1:0]};
  assign unused_addr_lo = ^cpu_addr[1:0];

  // A held entry already reserves a slot, so it counts against MAX_OUT.
  assign cnt_ok    = !fifo_full && (({1'b0, out_cnt} + CW1'(hold_v_reg)) < MAX_V);
  // While holding, req is 1, so req && addr_ok reduces to addr_ok (keeps req out of this path).
  assign cpu_ready = (!hold_v_reg || addr_ok) && cnt_ok;
  assign accept    = cpu_valid && cpu_ready;

`ifdef SRAM_LIKE_BYPASS_EN
  assign direct = accept && !hold_v_reg;
`else
  assign direct = 1'b0;
`endif

  assign req   = hold_v_reg || direct;
  assign wr    = hold_v_reg ? hold_wr_reg : (direct && cpu_wr);
  assign size  = direct ? enc[3:2] : hold_size_reg;
  assign addr  = direct ? cpu_bus_addr : hold_addr_reg;
  assign wdata = direct ? cpu_wdata : hold_wdata_reg;
  assign issue = req && addr_ok;
  assign pop   = data_ok && (out_cnt != '0);

  // Fields are always captured so they keep their last value once req drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_reg     <= 1'b0;
      hold_wr_reg    <= 1'b0;
      hold_size_reg  <= 2'd0;
      hold_addr_reg  <= '0;
      hold_wdata_reg <= 32'd0;
    end else if (accept) begin
      hold_v_reg     <= !(direct && addr_ok);
      hold_wr_reg    <= cpu_wr;
      hold_size_reg  <= enc[3:2];
      hold_addr_reg  <= cpu_bus_addr;
      hold_wdata_reg <= cpu_wdata;
    end else if (issue) begin
      hold_v_reg <= 1'b0;
    end
  end

  sram_like_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue),
    .push_data (wr),
    .pop       (pop),
    .head      (head_wr),
    .count     (out_cnt),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_reg <= 1'b0;
      resp_reg       <= '0;
    end else begin
      resp_valid_reg <= pop;
      resp_reg.wr    <= pop && head_wr;
      resp_reg.rdata <= (pop && !head_wr) ? rdata : 32'd0;
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_wr    = resp_reg.wr;
  assign resp_rdata = resp_reg.rdata;

`ifdef SRAM_LIKE_BRIDGE_ASSERT
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(data_ok && (out_cnt == '0)))
        else $error("sram_like_bridge: data_ok with no outstanding transaction");
    end
  end
`endif

endmodule
